// File: rtl/lights_out_game_ctrl.sv
// Lights-out 3x3 game controller: synchronized button/new-game edge detection,
// press handling with neighbour toggles, LFSR-driven board scramble and win detection.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PLAY     | accepting presses, watching for a cleared board
// SCRAMBLE | drawing random cells into the board in blocks of 16, busy = 1
// WON      | board solved; presses ignored, only new_game leaves
module lights_out_game_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [8:0] btn,
    input  logic       new_game,
    output logic [8:0] field,
    output logic       won,
    output logic       busy,
    output logic [7:0] moves
);

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        SCRAMBLE = 2'd1,
        WON      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  field_q, field_d;
    logic [7:0]  moves_q, moves_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  draw_q, draw_d;

    logic [8:0]  btn_s1_q, btn_s2_q, btn_h_q;
    logic        ng_s1_q, ng_s2_q, ng_h_q;
    logic [8:0]  btn_edge;
    logic        ng_edge;

    logic        press_found;
    logic [3:0]  press_idx;
    logic [3:0]  draw_nib;
    logic [3:0]  draw_idx;
    logic [8:0]  scr_field;

    // Cell plus its orthogonal neighbours on the 3x3 board.
    function automatic logic [8:0] toggle_mask(input logic [3:0] idx);
        logic [8:0] m;
        case (idx)
            4'd0:    m = 9'h00B;
            4'd1:    m = 9'h017;
            4'd2:    m = 9'h026;
            4'd3:    m = 9'h059;
            4'd4:    m = 9'h0BA;
            4'd5:    m = 9'h134;
            4'd6:    m = 9'h0C8;
            4'd7:    m = 9'h1D0;
            4'd8:    m = 9'h1A0;
            default: m = 9'h000;
        endcase
        return m;
    endfunction

    assign btn_edge = btn_s2_q & ~btn_h_q;
    assign ng_edge  = ng_s2_q & ~ng_h_q;

    // Two-stage synchronizers plus history registers for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            btn_h_q  <= '0;
            ng_s1_q  <= 1'b0;
            ng_s2_q  <= 1'b0;
            ng_h_q   <= 1'b0;
        end else if (ena) begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            btn_h_q  <= btn_s2_q;
            ng_s1_q  <= new_game;
            ng_s2_q  <= ng_s1_q;
            ng_h_q   <= ng_s2_q;
        end
    end

    // Lowest-index press wins; scanning downward lets lower indices overwrite.
    always_comb begin
        press_found = 1'b0;
        press_idx   = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (btn_edge[i]) begin
                press_found = 1'b1;
                press_idx   = 4'(i);
            end
        end
    end

    // Fold the 0..15 LFSR nibble onto a board cell.
    assign draw_nib  = lfsr_q[3:0];
    assign draw_idx  = (draw_nib < 4'd9) ? draw_nib : (draw_nib - 4'd9);
    assign scr_field = field_q ^ toggle_mask(draw_idx);

    // Next-state, board and counter update.
    always_comb begin
        state_d = state_q;
        field_d = field_q;
        moves_d = moves_q;
        draw_d  = draw_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        case (state_q)
            PLAY: begin
                if (ng_edge) begin
                    state_d = SCRAMBLE;
                    field_d = '0;
                    moves_d = '0;
                    draw_d  = '0;
                end else if (field_q == 9'h000) begin
                    state_d = WON;
                end else if (press_found) begin
                    field_d = field_q ^ toggle_mask(press_idx);
                    if (moves_q != 8'hFF) begin
                        moves_d = moves_q + 8'd1;
                    end
                end
            end
            SCRAMBLE: begin
                field_d = scr_field;
                draw_d  = draw_q + 4'd1;
                // A zero board after a 16-draw block simply runs another block.
                if (draw_q == 4'd15 && scr_field != 9'h000) begin
                    state_d = PLAY;
                end
            end
            WON: begin
                if (ng_edge) begin
                    state_d = SCRAMBLE;
                    field_d = '0;
                    moves_d = '0;
                    draw_d  = '0;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    // Game state registers; reset dominates the enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PLAY;
            field_q <= 9'h010;
            moves_q <= '0;
            lfsr_q  <= 16'hACE1;
            draw_q  <= '0;
        end else if (ena) begin
            state_q <= state_d;
            field_q <= field_d;
            moves_q <= moves_d;
            lfsr_q  <= lfsr_d;
            draw_q  <= draw_d;
        end
    end

    assign field = field_q;
    assign moves = moves_q;
    assign won   = (state_q == WON);
    assign busy  = (state_q == SCRAMBLE);

endmodule

// File: tb/tb_lights_out_game_ctrl.sv
// Bench for lights_out_game_ctrl: table of press scenarios, hand-written
// multi-cycle sequences, and a randomized run against a board-level model.
module tb_lights_out_game_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [8:0] btn;
    logic       new_game;
    logic [8:0] field;
    logic       won;
    logic       busy;
    logic [7:0] moves;

    int n_vec;
    int n_bad;

    lights_out_game_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .btn      (btn),
        .new_game (new_game),
        .field    (field),
        .won      (won),
        .busy     (busy),
        .moves    (moves)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: game mode 0 = playing, 1 = scrambling, 2 = solved.
    int          m_mode;
    logic [8:0]  m_field;
    int          m_moves;
    logic [15:0] m_lfsr;
    int          m_draws;
    logic [8:0]  b_hist [0:2];
    logic        n_hist [0:2];

    function automatic logic [8:0] cell_mask(input int i);
        int r, c;
        logic [8:0] m;
        r = i / 3;
        c = i % 3;
        m = '0;
        m[i] = 1'b1;
        if (r > 0) m[i-3] = 1'b1;
        if (r < 2) m[i+3] = 1'b1;
        if (c > 0) m[i-1] = 1'b1;
        if (c < 2) m[i+1] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        // taps from exponents 16,14,13,11 of the polynomial
        logic fb;
        fb = v[16-1] ^ v[14-1] ^ v[13-1] ^ v[11-1];
        return {v[14:0], fb};
    endfunction

    task automatic model_step();
        logic [8:0] bedge;
        logic       nedge;
        int         sel, k;
        if (!rst_n) begin
            m_mode = 0; m_field = 9'h010; m_moves = 0; m_lfsr = 16'hACE1; m_draws = 0;
            for (int i = 0; i < 3; i++) begin b_hist[i] = '0; n_hist[i] = 1'b0; end
            return;
        end
        if (!ena) return;
        // An input seen two enabled edges ago that was low three edges ago is a fresh press.
        bedge = b_hist[1] & ~b_hist[2];
        nedge = n_hist[1] & ~n_hist[2];
        b_hist[2] = b_hist[1]; b_hist[1] = b_hist[0]; b_hist[0] = btn;
        n_hist[2] = n_hist[1]; n_hist[1] = n_hist[0]; n_hist[0] = new_game;
        if (m_mode == 1) begin
            k = m_lfsr % 16;
            if (k >= 9) k = k - 9;
            m_field = m_field ^ cell_mask(k);
            m_draws = (m_draws + 1) % 16;
            if (m_draws == 0 && m_field != 0) m_mode = 0;
        end else if (nedge) begin
            m_mode = 1; m_field = '0; m_moves = 0; m_draws = 0;
        end else if (m_mode == 0) begin
            if (m_field == 0) m_mode = 2;
            else if (bedge != 0) begin
                sel = -1;
                for (int i = 0; i < 9; i++) if (sel < 0 && bedge[i]) sel = i;
                m_field = m_field ^ cell_mask(sel);
                if (m_moves < 255) m_moves = m_moves + 1;
            end
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("lockstep", {13'd0, field, moves, won, busy},
              {13'd0, m_field, 8'(m_moves), m_mode == 2, m_mode == 1});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [8:0] pat);
        btn = pat;
        tick();
        btn = '0;
        repeat (4) tick();
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    // Start a scramble and verify its length and outcome; bounded waits.
    task automatic run_scramble(input string tag);
        int cnt, guard;
        pulse_new_game();
        guard = 0;
        while (!busy && guard < 20) begin tick(); guard++; end
        check({tag, "_busy_seen"}, busy, 1);
        cnt = 0;
        while (busy && cnt < 400) begin tick(); cnt++; end
        check({tag, "_len_mod16"}, cnt % 16, 0);
        check({tag, "_len_nz"}, cnt != 0, 1);
        check({tag, "_field_nz"}, field != 0, 1);
        check({tag, "_moves"}, moves, 0);
        check({tag, "_won"}, won, 0);
    endtask

    typedef struct {
        logic       rst;
        logic [8:0] pat;
        logic [8:0] exp_field;
        logic [7:0] exp_moves;
        logic       exp_won;
    } vec_t;

    vec_t tbl [0:10];

    initial begin
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; ena = 1'b1; btn = '0; new_game = 1'b0;

        tbl[0]  = '{1'b1, 9'h000, 9'h010, 8'd0, 1'b0};
        tbl[1]  = '{1'b1, 9'h010, 9'h0AA, 8'd1, 1'b0};
        tbl[2]  = '{1'b1, 9'h001, 9'h01B, 8'd1, 1'b0};
        tbl[3]  = '{1'b0, 9'h001, 9'h010, 8'd2, 1'b0};
        tbl[4]  = '{1'b1, 9'h002, 9'h007, 8'd1, 1'b0};
        tbl[5]  = '{1'b0, 9'h008, 9'h05E, 8'd2, 1'b0};
        tbl[6]  = '{1'b0, 9'h010, 9'h0E4, 8'd3, 1'b0};
        tbl[7]  = '{1'b0, 9'h020, 9'h1D0, 8'd4, 1'b0};
        tbl[8]  = '{1'b0, 9'h080, 9'h000, 8'd5, 1'b1};
        tbl[9]  = '{1'b0, 9'h100, 9'h000, 8'd5, 1'b1};
        tbl[10] = '{1'b1, 9'h044, 9'h036, 8'd1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) do_reset();
            if (tbl[i].pat != 0) press(tbl[i].pat);
            check($sformatf("tbl%0d_field", i), field, tbl[i].exp_field);
            check($sformatf("tbl%0d_moves", i), moves, tbl[i].exp_moves);
            check($sformatf("tbl%0d_won", i), won, tbl[i].exp_won);
            check($sformatf("tbl%0d_busy", i), busy, 0);
        end

        // New game from the solved board, then from play.
        run_scramble("scr_from_won");
        run_scramble("scr_from_play");

        // Disabled clock: a press is invisible and nothing advances.
        do_reset();
        ena = 1'b0;
        btn = 9'h010;
        repeat (3) tick();
        btn = '0;
        repeat (3) tick();
        ena = 1'b1;
        repeat (4) tick();
        check("ena_off_field", field, 9'h010);
        check("ena_off_moves", moves, 0);
        run_scramble("scr_after_freeze");

        // Moves counter saturation.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            btn = 9'h010; tick();
            btn = '0;     tick();
        end
        repeat (4) tick();
        check("sat_moves", moves, 8'd255);
        check("sat_field", field, 9'h010);

        // Button held through reset release yields exactly one press.
        btn = 9'h010;
        do_reset();
        repeat (8) tick();
        btn = '0;
        repeat (3) tick();
        check("held_field", field, 9'h0AA);
        check("held_moves", moves, 1);

        // new_game edge together with a press: press dropped.
        do_reset();
        btn = 9'h001; new_game = 1'b1;
        tick();
        btn = '0; new_game = 1'b0;
        tick(); tick();
        check("ng_prio_busy", busy, 1);
        check("ng_prio_moves", moves, 0);

        // Reset in the middle of a scramble.
        repeat (5) tick();
        do_reset();
        repeat (20) tick();
        check("abort_field", field, 9'h010);
        check("abort_busy", busy, 0);

        // Randomized run in lockstep with the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            ena      = ($urandom % 8) != 0;
            btn      = (($urandom % 5) == 0) ? 9'($urandom) : 9'h000;
            new_game = ($urandom % 60) == 0;
            rst_n    = ($urandom % 400) != 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lights_out_game_ctrl.md
LIGHTS_OUT_GAME_CTRL -- requirements
Module: lights_out_game_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; rst_n  input  1  reset, synchronous, active-low.
REQ-002 SHALL have port: ena  input  1  clock enable; low freezes all registers.
REQ-003 SHALL have port: btn  input  9  asynchronous cell buttons, index 0..8, row-major over the 3x3 board.
REQ-004 SHALL have port: new_game  input  1  asynchronous request to scramble a fresh board.
REQ-005 SHALL have port: field  output  9  current light state, 1 = lit, same indexing as btn.
REQ-006 SHALL have ports: won  output  1  board solved; busy  output  1  scramble in progress; moves  output  8  player press count.

Function
REQ-007 SHALL pass btn and new_game through a 2-FF synchronizer plus a history register each; edge = sync & ~history.
REQ-008 SHALL define toggle mask for cell i as i plus its orthogonal neighbours: 0:0x00B 1:0x017 2:0x026 3:0x059 4:0x0BA 5:0x134 6:0x0C8 7:0x1D0 8:0x1A0.
REQ-009 SHALL implement FSM states PLAY, SCRAMBLE, WON, and SHALL enter PLAY on reset.
REQ-010 PLAY: on a btn edge, field ^= mask(i), moves += 1 saturating at 255, both in the same clock as the edge.
REQ-011 Simultaneous btn edges SHALL be resolved by accepting the lowest index only; the other edges are discarded, not queued.
REQ-012 Latency: btn rising before clock edge k SHALL change field at edge k+2.
REQ-013 PLAY -> WON in the cycle after field becomes 0x000; won = 1 in WON only.
REQ-014 WON: all btn edges ignored; field, moves held.
REQ-015 A new_game edge in PLAY or WON SHALL enter SCRAMBLE next cycle, load field = 0x000, moves = 0, and clear the draw counter.
REQ-016 A new_game edge in the same cycle as a btn edge SHALL take priority; the press is discarded.
REQ-017 SCRAMBLE: btn and new_game edges ignored; busy = 1.
REQ-018 SCRAMBLE: each cycle, idx = lfsr[3:0] if < 9, else lfsr[3:0] - 9; field ^= mask(idx); the 4-bit draw counter increments.
REQ-019 SCRAMBLE end: after the 16th draw, go to PLAY if field != 0x000, otherwise run another 16 draws.
REQ-020 LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left with feedback into bit 0.
REQ-021 LFSR SHALL advance every enabled cycle in all states and SHALL never reach zero.
REQ-022 ena = 0 SHALL hold the FSM, field, moves, LFSR, counters and synchronizers unchanged.

Reset
REQ-023 On rst_n = 0 at a clock edge, regardless of ena: state = PLAY, field = 0x010, moves = 0, won = 0, busy = 0, lfsr = 0xACE1, draw counter = 0.
REQ-024 Reset SHALL set synchronizer and history registers to 0; a button already held at reset release SHALL produce exactly one edge.
REQ-025 Reset mid-SCRAMBLE SHALL abort the scramble with no residual draws.

Verification
REQ-026 Reset, press btn[4] once: field = 0x0AA, moves = 1, won = 0.
REQ-027 Reset, press btn[0] twice (separate pulses): field = 0x010, moves = 2.
REQ-028 Reset, press btn 1,3,4,5,7 in sequence: field = 0x000, won = 1, moves = 5; further presses leave field and moves unchanged.
REQ-029 Raise btn[2] and btn[6] in the same cycle: field = 0x010 ^ 0x026 = 0x036, moves = 1.
REQ-030 new_game from PLAY: busy = 1 for 16 cycles (32 if the result is zero); then field != 0, moves = 0, won = 0, and the field matches the reference-model LFSR replay.
REQ-031 ena = 0 while pressing btn[4]: field, moves and lfsr unchanged; press 256 times: moves saturates at 255.
